// File: rtl/byteswap_sched_pkg.sv
// Shared types for the byteswap job scheduler.
//   sched_state_e : scheduler FSM states
//   job_desc_t    : queued job descriptor (base byte address, length in bytes)
// Descriptor fields are sized for the widest supported configuration. The
// scheduler narrows them back to its own parameter widths.
package byteswap_sched_pkg;

  localparam int unsigned DESC_ADDR_W = 64;
  localparam int unsigned DESC_SIZE_W = 32;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] addr;
    logic [DESC_SIZE_W-1:0] size;
  } job_desc_t;

endpackage

// File: rtl/byteswap_job_fifo.sv
// Synchronous job descriptor FIFO.
//   ap_clk, areset : clock, async active-high reset (empties the queue)
//   push, wr_data  : enqueue when not full
//   pop            : dequeue when not empty
//   head           : descriptor at the read pointer (valid when !empty)
//   full, empty    : occupancy flags decoded from the pointers
// Pointers carry one extra wrap bit so full and empty can be told apart.
module byteswap_job_fifo
  import byteswap_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      ap_clk,
  input  logic      areset,
  input  logic      push,
  input  job_desc_t wr_data,
  input  logic      pop,
  output job_desc_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  job_desc_t     mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop may occur in the same cycle.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: slots are only read after being written.
  always_ff @(posedge ap_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/byteswap_job_sched.sv
// Byteswap job scheduler: queues job descriptors and splits each job into
// engine runs of at most C_CHUNK_BYTES, issuing them one at a time.
//   ap_clk, areset             : clock, async active-high reset
//   job_valid/job_ready        : descriptor handshake (ready = queue not full)
//   job_addr, job_size         : job base byte address and length
//   eng_start/eng_done         : one-cycle start pulse / completion pulse
//   eng_addr, eng_size         : chunk address and length, held over a run
//   busy                       : FSM active or jobs queued
//   job_done, jobs_completed   : per-job completion pulse and wrapping count
module byteswap_job_sched
  import byteswap_sched_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned C_CHUNK_BYTES     = 16384,
  parameter int unsigned C_QUEUE_DEPTH     = 4
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [C_ADDR_WIDTH-1:0]      job_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0] job_size,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic [C_ADDR_WIDTH-1:0]      eng_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0] eng_size,
  output logic                         busy,
  output logic                         job_done,
  output logic [CNT_W-1:0]             jobs_completed
);

  localparam logic [C_XFER_SIZE_WIDTH-1:0] CHUNK_SZ = C_XFER_SIZE_WIDTH'(C_CHUNK_BYTES);

  sched_state_e                 state;
  logic [C_ADDR_WIDTH-1:0]      cur_addr;
  logic [C_XFER_SIZE_WIDTH-1:0] remain;
  logic [C_ADDR_WIDTH-1:0]      addr_nxt;
  logic [C_XFER_SIZE_WIDTH-1:0] remain_nxt;

  job_desc_t wr_desc;
  job_desc_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;

  function automatic logic [C_XFER_SIZE_WIDTH-1:0] chunk_len(
    input logic [C_XFER_SIZE_WIDTH-1:0] bytes_left
  );
    return (bytes_left > CHUNK_SZ) ? CHUNK_SZ : bytes_left;
  endfunction

  assign wr_desc.addr = DESC_ADDR_W'(job_addr);
  assign wr_desc.size = DESC_SIZE_W'(job_size);
  assign job_ready    = !fifo_full;
  assign fifo_push    = job_valid && !fifo_full;
  assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
  assign busy         = (state != ST_IDLE) || !fifo_empty;

  // Position after the chunk in flight; the address wraps with no carry out.
  assign addr_nxt   = cur_addr + C_ADDR_WIDTH'(eng_size);
  assign remain_nxt = remain - eng_size;

  byteswap_job_fifo #(
    .DEPTH (C_QUEUE_DEPTH)
  ) u_fifo (
    .ap_clk  (ap_clk),
    .areset  (areset),
    .push    (fifo_push),
    .wr_data (wr_desc),
    .pop     (fifo_pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Scheduler FSM. eng_* and job_done are loaded on entry to START/DONE so
  // they are registered and valid for the whole state.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state          <= ST_IDLE;
      cur_addr       <= '0;
      remain         <= '0;
      eng_start      <= 1'b0;
      eng_addr       <= '0;
      eng_size       <= '0;
      job_done       <= 1'b0;
      jobs_completed <= '0;
    end else begin
      eng_start <= 1'b0;
      job_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_addr <= C_ADDR_WIDTH'(head.addr);
            remain   <= C_XFER_SIZE_WIDTH'(head.size);
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (remain == '0) begin
            job_done       <= 1'b1;
            jobs_completed <= jobs_completed + CNT_W'(1);
            state          <= ST_DONE;
          end else begin
            eng_start <= 1'b1;
            eng_addr  <= cur_addr;
            eng_size  <= chunk_len(remain);
            state     <= ST_START;
          end
        end
        ST_START: state <= ST_WAIT;
        // eng_done only has an effect here; pulses in other states are dropped.
        ST_WAIT: begin
          if (eng_done) begin
            cur_addr <= addr_nxt;
            remain   <= remain_nxt;
            if (remain_nxt == '0) begin
              job_done       <= 1'b1;
              jobs_completed <= jobs_completed + CNT_W'(1);
              state          <= ST_DONE;
            end else begin
              eng_start <= 1'b1;
              eng_addr  <= addr_nxt;
              eng_size  <= chunk_len(remain_nxt);
              state     <= ST_START;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
